// File: rtl/updown_modulo_counter_if.sv
// ============================================================================
// Module      : updown_modulo_counter_if
// Description : Control and status bundle for the up/down modulo counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface updown_modulo_counter_if #(
  parameter int SIZE = 16
);
  logic            Enable;
  logic            Load;
  logic [SIZE-1:0] LoadValue;
  logic            Up;
  logic            Saturate;
  logic [SIZE-1:0] MaxValue;
  logic [SIZE-1:0] Q;
  logic            Wrap;
  logic            AtMax;
  logic            AtZero;

  modport master (
    output Enable, Load, LoadValue, Up, Saturate, MaxValue,
    input  Q, Wrap, AtMax, AtZero
  );

  modport slave (
    input  Enable, Load, LoadValue, Up, Saturate, MaxValue,
    output Q, Wrap, AtMax, AtZero
  );
endinterface

`default_nettype wire

// File: rtl/updown_modulo_counter.sv
// ============================================================================
// Module      : updown_modulo_counter
// Description : Up/down counter with runtime terminal value, clipped load,
//               wrap/saturate mode and a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_modulo_counter #(
  parameter int          SIZE        = 16,
  parameter int unsigned RESET_VALUE = 0
) (
  input  wire logic                     Clock,
  input  wire logic                     Reset,
  updown_modulo_counter_if.slave        bus
);

  localparam logic [SIZE-1:0] c_RESET = RESET_VALUE[SIZE-1:0];
  localparam logic [SIZE-1:0] c_ONE   = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] c_ZERO  = '0;

  logic [SIZE-1:0] r_q;
  logic            r_wrap;
  logic [SIZE-1:0] w_q_next;
  logic            w_wrap_next;

  // Limit comparisons are made on the current value before any arithmetic,
  // so the increment never needs a carry bit beyond SIZE.
  always_comb begin
    w_q_next    = r_q;
    w_wrap_next = 1'b0;
    if (bus.Load) begin
      w_q_next = (bus.LoadValue > bus.MaxValue) ? bus.MaxValue : bus.LoadValue;
    end else if (bus.Enable) begin
      if (bus.Up) begin
        if (r_q >= bus.MaxValue) begin
          if (bus.Saturate) begin
            w_q_next = bus.MaxValue;
          end else begin
            w_q_next    = c_ZERO;
            w_wrap_next = 1'b1;
          end
        end else begin
          w_q_next = r_q + c_ONE;
        end
      end else begin
        // An out-of-range count after MaxValue was lowered snaps to the limit.
        if (r_q > bus.MaxValue) begin
          w_q_next = bus.MaxValue;
        end else if (r_q == c_ZERO) begin
          if (!bus.Saturate) begin
            w_q_next    = bus.MaxValue;
            w_wrap_next = 1'b1;
          end
        end else begin
          w_q_next = r_q - c_ONE;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q    <= c_RESET;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.Q      = r_q;
  assign bus.Wrap   = r_wrap;
  assign bus.AtMax  = (r_q >= bus.MaxValue);
  assign bus.AtZero = (r_q == c_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_updown_modulo_counter.sv
// ============================================================================
// Module      : tb_updown_modulo_counter
// Description : Directed scoreboard bench for updown_modulo_counter, SIZE=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_modulo_counter;

  localparam int c_SIZE = 4;

  typedef struct packed {
    logic [c_SIZE-1:0] q;
    logic              wrap;
    logic              atmax;
    logic              atzero;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  updown_modulo_counter_if #(.SIZE(c_SIZE)) bus ();

  updown_modulo_counter #(.SIZE(c_SIZE), .RESET_VALUE(0)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  exp_t  r_exp_q[$];
  string r_name_q[$];
  int    r_total  = 0;
  int    r_passed = 0;

  // Monitor: compares the DUT state against the oldest queued expectation.
  initial begin
    exp_t  e;
    exp_t  a;
    string n;
    forever begin
      @(negedge Clock);
      if (r_exp_q.size() > 0) begin
        e = r_exp_q.pop_front();
        n = r_name_q.pop_front();
        a = '{q: bus.Q, wrap: bus.Wrap, atmax: bus.AtMax, atzero: bus.AtZero};
        r_total++;
        if (a === e) r_passed++;
        else $display("FAIL %s: got Q=%0d Wrap=%b AtMax=%b AtZero=%b, want Q=%0d Wrap=%b AtMax=%b AtZero=%b",
                      n, a.q, a.wrap, a.atmax, a.atzero, e.q, e.wrap, e.atmax, e.atzero);
      end
    end
  end

  // One clock of stimulus; expected values are the hand-computed Q and Wrap.
  task automatic cyc(input logic rst, input logic en, input logic ld, input int lv,
                     input logic up, input logic sat, input int mv,
                     input int exp_q, input logic exp_w, input string name);
    exp_t e;
    Reset         = rst;
    bus.Enable    = en;
    bus.Load      = ld;
    bus.LoadValue = lv[c_SIZE-1:0];
    bus.Up        = up;
    bus.Saturate  = sat;
    bus.MaxValue  = mv[c_SIZE-1:0];
    @(posedge Clock);
    #1;
    e.q      = exp_q[c_SIZE-1:0];
    e.wrap   = exp_w;
    e.atmax  = (exp_q >= mv);
    e.atzero = (exp_q == 0);
    r_exp_q.push_back(e);
    r_name_q.push_back(name);
    @(negedge Clock);
    #1;
  endtask

  initial begin
    int wait_cycles;
    bus.Enable = 1'b0; bus.Load = 1'b0; bus.LoadValue = '0;
    bus.Up = 1'b1; bus.Saturate = 1'b0; bus.MaxValue = 4'd5;
    @(negedge Clock);
    #1;

    cyc(1, 0, 0, 0, 1, 0, 5, 0, 0, "reset");

    // Wrap mode counting up to 5
    cyc(0, 1, 0, 0, 1, 0, 5, 1, 0, "up_wrap_1");
    cyc(0, 1, 0, 0, 1, 0, 5, 2, 0, "up_wrap_2");
    cyc(0, 1, 0, 0, 1, 0, 5, 3, 0, "up_wrap_3");
    cyc(0, 1, 0, 0, 1, 0, 5, 4, 0, "up_wrap_4");
    cyc(0, 1, 0, 0, 1, 0, 5, 5, 0, "up_wrap_5_atmax");
    cyc(0, 1, 0, 0, 1, 0, 5, 0, 1, "up_wrap_to_0");
    cyc(0, 1, 0, 0, 1, 0, 5, 1, 0, "up_wrap_after");

    // Saturate up then down
    cyc(0, 0, 1, 3, 1, 1, 5, 3, 0, "sat_load3");
    cyc(0, 1, 0, 0, 1, 1, 5, 4, 0, "sat_up_4");
    cyc(0, 1, 0, 0, 1, 1, 5, 5, 0, "sat_up_5");
    cyc(0, 1, 0, 0, 1, 1, 5, 5, 0, "sat_up_hold_a");
    cyc(0, 1, 0, 0, 1, 1, 5, 5, 0, "sat_up_hold_b");
    cyc(0, 1, 0, 0, 1, 1, 5, 5, 0, "sat_up_hold_c");
    cyc(0, 1, 0, 0, 0, 1, 5, 4, 0, "sat_dn_4");
    cyc(0, 1, 0, 0, 0, 1, 5, 3, 0, "sat_dn_3");
    cyc(0, 1, 0, 0, 0, 1, 5, 2, 0, "sat_dn_2");
    cyc(0, 1, 0, 0, 0, 1, 5, 1, 0, "sat_dn_1");
    cyc(0, 1, 0, 0, 0, 1, 5, 0, 0, "sat_dn_0");
    cyc(0, 1, 0, 0, 0, 1, 5, 0, 0, "sat_dn_hold_a");
    cyc(0, 1, 0, 0, 0, 1, 5, 0, 0, "sat_dn_hold_b");

    // Down wrap with MaxValue 9
    cyc(0, 0, 1, 1, 0, 0, 9, 1, 0, "dn_load1");
    cyc(0, 1, 0, 0, 0, 0, 9, 0, 0, "dn_wrap_0");
    cyc(0, 1, 0, 0, 0, 0, 9, 9, 1, "dn_wrap_9");
    cyc(0, 1, 0, 0, 0, 0, 9, 8, 0, "dn_wrap_8");
    cyc(0, 0, 0, 0, 0, 0, 9, 8, 0, "hold_disabled");

    // Load clipping and priority
    cyc(0, 0, 1, 12, 1, 0, 7, 7, 0, "load_clip");
    cyc(0, 1, 1, 3, 1, 0, 7, 3, 0, "load_over_enable");
    cyc(1, 1, 1, 5, 1, 0, 7, 0, 0, "reset_over_load");

    // MaxValue lowered below the current count
    cyc(0, 0, 1, 10, 1, 0, 15, 10, 0, "load10");
    cyc(0, 1, 0, 0, 1, 0, 6, 0, 1, "lowered_up_wrap");
    cyc(0, 0, 1, 10, 1, 0, 15, 10, 0, "load10_again");
    cyc(0, 0, 0, 0, 0, 0, 6, 10, 0, "lowered_atmax_hold");
    cyc(0, 1, 0, 0, 0, 0, 6, 6, 0, "lowered_dn_snap");

    // Full binary wrap with MaxValue all-ones
    cyc(1, 0, 0, 0, 1, 0, 15, 0, 0, "reset_full");
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 0, 0, 1, 0, 15, (i + 1) % 16, (i == 15), $sformatf("full_wrap_%0d", i));

    // MaxValue 0 in wrap mode pulses every enabled cycle
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 1, "mv0_up_a");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 1, "mv0_up_b");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 1, "mv0_up_c");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, "mv0_dn_a");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, "mv0_dn_b");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "mv0_disabled");

    wait_cycles = 0;
    while (r_exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge Clock);
      wait_cycles++;
    end
    if (r_exp_q.size() > 0) begin
      r_total++;
      $display("FAIL drain: got %0d pending expectations, want 0", r_exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", r_passed, r_total);
    $finish;
  end

endmodule

`default_nettype wire
